hazard_track_unit: RTL and testbench
====================================

Name: hazard_track_unit

Overview:
- Sits in the decode stage, directly upstream of the forwarding unit.
- Keeps a two-slot shadow pipeline (EX, MEM) of in-flight destination register numbers and memory-to-register flags. These slots drive the forwarding unit's old-destination number and M2R inputs.
- Detects load-use hazards and stalls fetch/decode for one cycle while inserting a bubble into EX.
- Sequences a multi-cycle flush when a taken branch is reported from EX.

Parameters:
- REG_W, 3, register-number width.
- FLUSH_CYCLES, 2, number of cycles the flush output stays asserted after a flush request (1..7).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  a real instruction is present in decode.
- id_src1  in  REG_W  decode source-1 register number.
- id_src2  in  REG_W  decode source-2 register number.
- id_src1_used  in  1  source 1 is read by the instruction.
- id_src2_used  in  1  source 2 is read by the instruction.
- id_dst  in  REG_W  decode destination register number.
- id_dst_wr  in  1  instruction writes id_dst.
- id_m2r  in  1  instruction is a load (result comes from memory).
- ex_flush_req  in  1  taken branch/jump resolved in EX (single-cycle pulse).
- stall_pc  out  1  hold the PC.
- stall_ifid  out  1  hold the IF/ID register.
- bubble_idex  out  1  load a NOP into ID/EX.
- flush_ifid  out  1  clear the IF/ID register.
- ex_dst_num  out  REG_W  EX slot destination (forwarding unit Old_Dst_1).
- ex_dst_vld  out  1  EX slot writes a register.
- ex_m2r  out  1  EX slot is a load.
- mem_dst_num  out  REG_W  MEM slot destination (forwarding unit Old_Dst_2).
- mem_dst_vld  out  1  MEM slot writes a register.
- mem_m2r  out  1  MEM slot is a load.

Behaviour:
- Reset: all slot registers cleared (num=0, vld=0, m2r=0); FSM=RUN; flush counter=0.
  - During rst, all stall, bubble and flush outputs are 0.
  - Reset mid-flush or mid-stall aborts the operation immediately.
- Hazard (combinational, same cycle): asserted when all of the following hold:
  - id_valid, ex_dst_vld and ex_m2r are all 1;
  - ex_dst_num == id_src1 with id_src1_used, or ex_dst_num == id_src2 with id_src2_used.
- The MEM slot never causes a stall; the forwarding unit covers it.
- On hazard, in FSM RUN:
  - stall_pc, stall_ifid and bubble_idex are all 1 in that cycle;
  - at the clock edge, MEM<=EX and EX<=empty (vld=0, m2r=0, num=0).
- The stall lasts exactly one cycle: the next cycle sees the load in MEM, so no hazard remains.
- Normal advance (no hazard, no flush): MEM<=EX; EX<={id_dst, id_dst_wr&id_valid, id_m2r&id_valid}.
- FSM states:
  - RUN -> FLUSH on ex_flush_req. Counter loads FLUSH_CYCLES-1.
  - FLUSH: flush_ifid=1 and bubble_idex=1. EX slot loads empty each cycle; MEM still advances. Counter decrements each cycle.
  - FLUSH -> RUN when the counter is 0 at the clock edge.
- Flush request cycle (still in RUN):
  - flush_ifid and bubble_idex are asserted combinationally;
  - EX loads empty;
  - stall_pc and stall_ifid are forced to 0 so the PC takes the branch target.
- Simultaneous ex_flush_req and hazard: the flush wins and no stall is asserted.
- ex_flush_req while already in FLUSH: the counter reloads FLUSH_CYCLES-1.
- Any hazard that appears during FLUSH is ignored.
- Slot outputs are registered and have zero combinational path from the id_* inputs.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - adds output stall_cnt (16 bits) and output flush_cnt (16 bits);
  - stall_cnt increments on each cycle with stall_ifid=1;
  - flush_cnt increments on each cycle with ex_flush_req=1;
  - both counters saturate at 16'hFFFF and clear on rst.
- When undefined: neither port nor the counter logic exists.

Decomposition:
- Shared package: the REG_W default, the FSM state encoding (RUN=1'b0, FLUSH=1'b1), and the empty-slot constant.
- Natural sub-module: dst_slot_reg, a single slot register holding {num, vld, m2r} with load and clear inputs. It is instantiated twice (EX, MEM).

Test Plan:
- Reset release, id_valid=0 for 3 cycles -> all outputs 0, slots empty.
- Load R3 (id_m2r=1, id_dst=3) followed by ADD with id_src1=3 -> stall_pc, stall_ifid and bubble_idex are 1 for exactly one cycle. The next cycle shows mem_dst_num=3 with mem_m2r=1 and ex_dst_vld=0.
- Non-load ADD to R5 followed by an instruction reading R5 -> no stall; ex_dst_num=5 and ex_dst_vld=1 one cycle later.
- Load R2 followed by an instruction with id_src2=2 but id_src2_used=0 -> no stall.
- ex_flush_req pulse with FLUSH_CYCLES=2 -> flush_ifid=1 for 2 consecutive cycles, EX slot empty in both, then RUN. A simultaneous hazard in the request cycle produces stall_pc=0.
- rst asserted during the second FLUSH cycle -> next cycle flush_ifid=0 and slots cleared. With HAZARD_PERF_CNT_EN, stall_cnt=0 after reset and equals 3 after three load-use pairs.

Source files
------------

// File: rtl/hazard_track_unit_pkg.sv
// Shared definitions for the decode-stage hazard tracker: default register width,
// FSM encoding and the empty-slot flag constant.
package hazard_track_unit_pkg;

  localparam int REG_W_DEFAULT = 3;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef struct packed {
    logic vld;
    logic m2r;
  } slot_flags_t;

  localparam slot_flags_t SLOT_FLAGS_EMPTY = '{vld: 1'b0, m2r: 1'b0};

endpackage

// File: rtl/hazard_track_unit_dst_slot_reg.sv
// One shadow-pipeline slot {num, vld, m2r}; clear has priority over load.
module dst_slot_reg
  import hazard_track_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [REG_W-1:0] d_num,
  input  slot_flags_t      d_flags,
  output logic [REG_W-1:0] q_num,
  output slot_flags_t      q_flags
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      q_num   <= '0;
      q_flags <= SLOT_FLAGS_EMPTY;
    end else if (load) begin
      q_num   <= d_num;
      q_flags <= d_flags;
    end
  end

endmodule

// File: rtl/hazard_track_unit.sv
// Decode-stage load-use stall and branch-flush sequencer with EX/MEM shadow slots.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_track_unit
  import hazard_track_unit_pkg::*;
#(
  parameter int REG_W        = REG_W_DEFAULT,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_src1_used,
  input  logic             id_src2_used,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_dst_wr,
  input  logic             id_m2r,
  input  logic             ex_flush_req,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             bubble_idex,
  output logic             flush_ifid,
`ifdef HAZARD_PERF_CNT_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
`endif
  output logic [REG_W-1:0] ex_dst_num,
  output logic             ex_dst_vld,
  output logic             ex_m2r,
  output logic [REG_W-1:0] mem_dst_num,
  output logic             mem_dst_vld,
  output logic             mem_m2r
);

  logic [0:0]  state;
  logic [2:0]  flush_left;
  logic        hazard;
  logic        flush_active;
  logic        stall;
  logic        ex_empty;
  slot_flags_t id_flags;
  slot_flags_t ex_flags;
  slot_flags_t mem_flags;

  always_comb begin
    hazard       = id_valid && ex_flags.vld && ex_flags.m2r &&
                   (((ex_dst_num == id_src1) && id_src1_used) ||
                    ((ex_dst_num == id_src2) && id_src2_used));
    flush_active = ex_flush_req || (state == ST_FLUSH);
    // A flush (request or in progress) overrides any stall so the PC can redirect.
    stall        = !rst && hazard && !flush_active;
    ex_empty     = flush_active || hazard;
    id_flags.vld = id_dst_wr && id_valid;
    id_flags.m2r = id_m2r && id_valid;
    stall_pc     = stall;
    stall_ifid   = stall;
    flush_ifid   = !rst && flush_active;
    bubble_idex  = stall || (!rst && flush_active);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      flush_left <= 3'd0;
    end else if (ex_flush_req) begin
      state      <= ST_FLUSH;
      flush_left <= 3'(FLUSH_CYCLES - 1);
    end else if (state == ST_FLUSH) begin
      if (flush_left == 3'd0) begin
        state <= ST_RUN;
      end else begin
        flush_left <= flush_left - 3'd1;
      end
    end
  end

  dst_slot_reg #(.REG_W(REG_W)) u_ex_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (1'b1),
    .clear   (ex_empty),
    .d_num   (id_dst),
    .d_flags (id_flags),
    .q_num   (ex_dst_num),
    .q_flags (ex_flags)
  );

  dst_slot_reg #(.REG_W(REG_W)) u_mem_slot (
    .clk     (clk),
    .rst     (rst),
    .load    (1'b1),
    .clear   (1'b0),
    .d_num   (ex_dst_num),
    .d_flags (ex_flags),
    .q_num   (mem_dst_num),
    .q_flags (mem_flags)
  );

  assign ex_dst_vld  = ex_flags.vld;
  assign ex_m2r      = ex_flags.m2r;
  assign mem_dst_vld = mem_flags.vld;
  assign mem_m2r     = mem_flags.m2r;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_ifid && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (ex_flush_req && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_track_unit.sv
// Randomized scoreboard bench for hazard_track_unit against a slot-level reference model.
module tb_hazard_track_unit;

  localparam int REG_W        = 3;
  localparam int FLUSH_CYCLES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             id_valid, id_src1_used, id_src2_used, id_dst_wr, id_m2r, ex_flush_req;
  logic [REG_W-1:0] id_src1, id_src2, id_dst;
  logic             stall_pc, stall_ifid, bubble_idex, flush_ifid;
  logic [REG_W-1:0] ex_dst_num, mem_dst_num;
  logic             ex_dst_vld, ex_m2r, mem_dst_vld, mem_m2r;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]      stall_cnt, flush_cnt;
`endif

  hazard_track_unit #(.REG_W(REG_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_src1_used (id_src1_used),
    .id_src2_used (id_src2_used),
    .id_dst       (id_dst),
    .id_dst_wr    (id_dst_wr),
    .id_m2r       (id_m2r),
    .ex_flush_req (ex_flush_req),
    .stall_pc     (stall_pc),
    .stall_ifid   (stall_ifid),
    .bubble_idex  (bubble_idex),
    .flush_ifid   (flush_ifid),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
`endif
    .ex_dst_num   (ex_dst_num),
    .ex_dst_vld   (ex_dst_vld),
    .ex_m2r       (ex_m2r),
    .mem_dst_num  (mem_dst_num),
    .mem_dst_vld  (mem_dst_vld),
    .mem_m2r      (mem_m2r)
  );

  typedef struct {
    bit stall;
    bit flush;
    int ex_num;
    bit ex_vld;
    bit ex_m2r;
    int mem_num;
    bit mem_vld;
    bit mem_m2r;
    int stall_cnt;
    int flush_cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: slot contents plus remaining flush cycles.
  int m_ex_num = 0, m_mem_num = 0;
  bit m_ex_vld = 0, m_ex_m2r = 0, m_mem_vld = 0, m_mem_m2r = 0;
  int m_flush_left = 0;
  int m_stall_cnt = 0, m_flush_cnt = 0;

  task automatic step(input bit v, input int s1, input int s2, input bit u1, input bit u2,
                      input int dst, input bit wr, input bit m2r, input bit fl, input bit r);
    exp_t e;
    bit   hz, fa;
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_src1 = REG_W'(s1); id_src2 = REG_W'(s2);
    id_src1_used = u1; id_src2_used = u2; id_dst = REG_W'(dst);
    id_dst_wr = wr; id_m2r = m2r; ex_flush_req = fl;

    fa = fl || (m_flush_left > 0);
    hz = v && m_ex_vld && m_ex_m2r && ((u1 && s1 == m_ex_num) || (u2 && s2 == m_ex_num));
    e.flush     = !r && fa;
    e.stall     = !r && hz && !fa;
    e.ex_num    = m_ex_num;  e.ex_vld  = m_ex_vld;  e.ex_m2r  = m_ex_m2r;
    e.mem_num   = m_mem_num; e.mem_vld = m_mem_vld; e.mem_m2r = m_mem_m2r;
    e.stall_cnt = m_stall_cnt;
    e.flush_cnt = m_flush_cnt;
    sb.push_back(e);

    if (r) begin
      m_ex_num = 0; m_ex_vld = 0; m_ex_m2r = 0;
      m_mem_num = 0; m_mem_vld = 0; m_mem_m2r = 0;
      m_flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
    end else begin
      m_mem_num = m_ex_num; m_mem_vld = m_ex_vld; m_mem_m2r = m_ex_m2r;
      if (fa || hz) begin
        m_ex_num = 0; m_ex_vld = 0; m_ex_m2r = 0;
      end else begin
        m_ex_num = dst; m_ex_vld = wr && v; m_ex_m2r = m2r && v;
      end
      if (fl) m_flush_left = FLUSH_CYCLES;
      else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
      if (e.stall && m_stall_cnt < 65535) m_stall_cnt = m_stall_cnt + 1;
      if (fl && m_flush_cnt < 65535) m_flush_cnt = m_flush_cnt + 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    if (act != exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors = vectors + 1;
      chk("stall_pc",    int'(stall_pc),    int'(e.stall));
      chk("stall_ifid",  int'(stall_ifid),  int'(e.stall));
      chk("bubble_idex", int'(bubble_idex), int'(e.stall || e.flush));
      chk("flush_ifid",  int'(flush_ifid),  int'(e.flush));
      chk("ex_dst_num",  int'(ex_dst_num),  e.ex_num);
      chk("ex_dst_vld",  int'(ex_dst_vld),  int'(e.ex_vld));
      chk("ex_m2r",      int'(ex_m2r),      int'(e.ex_m2r));
      chk("mem_dst_num", int'(mem_dst_num), e.mem_num);
      chk("mem_dst_vld", int'(mem_dst_vld), int'(e.mem_vld));
      chk("mem_m2r",     int'(mem_m2r),     int'(e.mem_m2r));
`ifdef HAZARD_PERF_CNT_EN
      chk("stall_cnt",   int'(stall_cnt),   e.stall_cnt);
      chk("flush_cnt",   int'(flush_cnt),   e.flush_cnt);
`endif
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_src1_used = 1'b0;
    id_src2_used = 1'b0; id_dst = '0; id_dst_wr = 1'b0; id_m2r = 1'b0; ex_flush_req = 1'b0;
    repeat (2) @(posedge clk);

    // Idle after reset release
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load R3 then dependent ADD (decode held for the stall cycle)
    step(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    step(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
    step(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
    // Non-load producer R5 then reader
    step(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    step(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Load R2, consumer lists R2 as unused src2
    step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    step(1, 1, 2, 1, 0, 7, 1, 0, 0, 0);
    // Flush request coinciding with a load-use hazard
    step(1, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    step(1, 4, 0, 1, 0, 1, 1, 0, 1, 0);
    repeat (3) step(1, 4, 0, 1, 0, 1, 1, 0, 0, 0);
    // Reset during the second flush cycle
    step(1, 0, 0, 0, 0, 3, 1, 1, 1, 0);
    step(1, 3, 0, 1, 0, 2, 1, 0, 0, 0);
    step(1, 3, 0, 1, 0, 2, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Three load-use pairs
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
      step(1, 0, 6, 0, 1, 1, 1, 0, 0, 0);
      step(1, 0, 6, 0, 1, 1, 1, 0, 0, 0);
    end

    // Randomized traffic with a small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
